// File: rtl/lfsr32_chk.sv
// rtl/lfsr32_chk.sv - self-synchronising PRBS checker for the lfsr32 sequence
// Seeds from the line, verifies the prediction, then flywheels and counts errors.
module lfsr32_chk #(
  parameter int LOCK_GOOD = 64,
  parameter int WINDOW    = 1024,
  parameter int LOSS_ERRS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             ARstb,
  input  logic             BitEn,
  input  logic             LFSRin,
  input  logic             ClrCnt,
  output logic             Locked,
  output logic             ErrPulse,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(WINDOW) + 1;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [31:0]       r_q,        r_d;
  logic [4:0]        seed_cnt_q, seed_cnt_d;
  logic [7:0]        good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q,  win_cnt_d;
  logic [WERR_W-1:0] win_err_q,  win_err_d;
  logic [CNT_W-1:0]  err_cnt_q,  err_cnt_d;
  logic              err_pulse_q, err_pulse_d;

  logic              pred;
  logic              err_hit;
  logic [WERR_W-1:0] win_err_inc;

  assign pred        = r_q[31] ^ r_q[21] ^ r_q[1] ^ r_q[0];
  assign err_hit     = BitEn && (state_q == ST_LOCKED) && (LFSRin != pred);
  assign win_err_inc = win_err_q + WERR_W'(err_hit);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = err_hit;

    if (BitEn) begin
      case (state_q)
        ST_SEED: begin
          r_d = {r_q[30:0], LFSRin};
          if (seed_cnt_q == 5'd31) begin
            state_d    = ST_VERIFY;
            seed_cnt_d = 5'd0;
            good_cnt_d = 8'd0;
          end else begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
        end
        ST_VERIFY: begin
          r_d = {r_q[30:0], LFSRin};
          // An all-zero history predicts zero forever, so it never counts as good.
          if ((LFSRin == pred) && (r_q != 32'd0)) begin
            if (good_cnt_q == 8'(LOCK_GOOD - 1)) begin
              state_d    = ST_LOCKED;
              good_cnt_d = 8'd0;
              win_cnt_d  = '0;
              win_err_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            good_cnt_d = 8'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: the prediction is fed back so one bad bit costs one error.
          r_d       = {r_q[30:0], pred};
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (win_err_inc == WERR_W'(LOSS_ERRS)) begin
            state_d    = ST_SEED;
            seed_cnt_d = 5'd0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_err_d = '0;
          end else begin
            win_err_d = win_err_inc;
          end
        end
        default: state_d = ST_SEED;
      endcase
    end

    if (ClrCnt) begin
      err_cnt_d = CNT_W'(err_hit);
    end else if (err_hit && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge ARstb) begin
    if (!ARstb) begin
      state_q     <= ST_SEED;
      r_q         <= 32'd0;
      seed_cnt_q  <= 5'd0;
      good_cnt_q  <= 8'd0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign Locked   = (state_q == ST_LOCKED);
  assign ErrPulse = err_pulse_q;
  assign ErrCnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr32_chk.sv
// tb/tb_lfsr32_chk.sv - scoreboard bench for lfsr32_chk
// Driver pushes model predictions; monitor pops one per clock and compares.
module tb_lfsr32_chk;

  localparam int LOCK_GOOD = 64;
  localparam int WINDOW    = 1024;
  localparam int LOSS_ERRS = 16;
  localparam int CNT_W     = 16;

  logic             Clk = 1'b0;
  logic             ARstb = 1'b0;
  logic             BitEn = 1'b0;
  logic             LFSRin = 1'b0;
  logic             ClrCnt = 1'b0;
  logic             Locked;
  logic             ErrPulse;
  logic [CNT_W-1:0] ErrCnt;

  lfsr32_chk #(
    .LOCK_GOOD(LOCK_GOOD), .WINDOW(WINDOW), .LOSS_ERRS(LOSS_ERRS), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .ARstb(ARstb), .BitEn(BitEn), .LFSRin(LFSRin), .ClrCnt(ClrCnt),
    .Locked(Locked), .ErrPulse(ErrPulse), .ErrCnt(ErrCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic             lock;
    logic             pulse;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  int   bits_sent = 0;
  int   lock_at = -1;
  int   loss_at = -1;
  int   lock_rises = 0;
  int   pulse_cycles = 0;
  logic mon_prev = 1'b0;
  logic             s_lock;
  logic [CNT_W-1:0] s_cnt;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: history kept as a bit queue, oldest first.
  bit m_hist[$];
  int m_state, m_cnt, m_win, m_werr, m_errcnt;

  function automatic void m_reset();
    m_hist = {};
    repeat (32) m_hist.push_back(1'b0);
    m_state = 0; m_cnt = 0; m_win = 0; m_werr = 0; m_errcnt = 0;
  endfunction

  function automatic void m_shift(bit v);
    m_hist.push_back(v);
    void'(m_hist.pop_front());
  endfunction

  function automatic exp_t m_step(bit en, bit x, bit clr);
    exp_t e;
    bit   p, pulse, zero;
    pulse = 1'b0;
    if (en) begin
      p = m_hist[0] ^ m_hist[10] ^ m_hist[30] ^ m_hist[31];
      if (m_state == 0) begin
        m_shift(x);
        m_cnt++;
        if (m_cnt == 32) begin m_state = 1; m_cnt = 0; end
      end else if (m_state == 1) begin
        zero = 1'b1;
        foreach (m_hist[i]) if (m_hist[i]) zero = 1'b0;
        if (x == p && !zero) m_cnt++; else m_cnt = 0;
        m_shift(x);
        if (m_cnt == LOCK_GOOD) begin m_state = 2; m_cnt = 0; m_win = 0; m_werr = 0; end
      end else begin
        pulse = (x != p);
        m_shift(p);
        m_win++;
        if (pulse) m_werr++;
        if (m_werr == LOSS_ERRS) begin
          m_state = 0; m_cnt = 0; m_werr = 0;
        end else if (m_win == WINDOW) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (clr) m_errcnt = int'(pulse);
    else if (pulse && m_errcnt < (2 ** CNT_W) - 1) m_errcnt++;
    e.lock  = (m_state == 2);
    e.pulse = pulse;
    e.cnt   = CNT_W'(m_errcnt);
    return e;
  endfunction

  // Transmitter: b[n] = b[n-32]^b[n-22]^b[n-2]^b[n-1], history oldest first.
  bit g_hist[$];

  function automatic void g_init(logic [31:0] seed);
    g_hist = {};
    for (int i = 31; i >= 0; i--) g_hist.push_back(seed[i]);
  endfunction

  function automatic bit g_next();
    bit v;
    v = g_hist[0] ^ g_hist[10] ^ g_hist[30] ^ g_hist[31];
    g_hist.push_back(v);
    void'(g_hist.pop_front());
    return v;
  endfunction

  task automatic send(bit en, bit x, bit clr);
    @(posedge Clk);
    #1;
    s_lock = Locked;
    s_cnt  = ErrCnt;
    #1;
    BitEn  = en;
    LFSRin = x;
    ClrCnt = clr;
    exp_q.push_back(m_step(en, x, clr));
    if (en) bits_sent++;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    ARstb = 1'b0;
    BitEn = 1'b0;
    ClrCnt = 1'b0;
    exp_q.delete();
    m_reset();
    #1;
    check("rst_locked", Locked, 0);
    check("rst_errpulse", ErrPulse, 0);
    check("rst_errcnt", ErrCnt, 0);
    repeat (2) @(posedge Clk);
    #2;
    ARstb = 1'b1;
    bits_sent = 0;
    lock_at = -1;
    loss_at = -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked", Locked, e.lock);
        check("errpulse", ErrPulse, e.pulse);
        check("errcnt", ErrCnt, e.cnt);
      end
      if (Locked && !mon_prev) begin lock_at = bits_sent; lock_rises++; end
      if (!Locked && mon_prev) loss_at = bits_sent;
      if (ErrPulse) pulse_cycles++;
      mon_prev = Locked;
    end
  end

  initial begin : driver
    int  pc, base, r0, en, b, guard;
    m_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("init_locked", Locked, 0);
    check("init_errcnt", ErrCnt, 0);
    #1;
    ARstb = 1'b1;

    // Clean stream from seed 1: lock after 96 bits, then no errors.
    g_init(32'h0000_0001);
    repeat (96) send(1, g_next(), 0);
    send(0, 0, 0);
    check("lock_latency", lock_at, 96);
    check("locked_after_96", s_lock, 1);
    repeat (5000) send(1, g_next(), 0);
    send(0, 0, 0);
    check("clean_errcnt", s_cnt, 0);

    // One corrupted bit: one pulse, count 1, lock held.
    pc = pulse_cycles;
    for (int i = 0; i < 100; i++) begin
      b = g_next();
      send(1, 1'(b) ^ (i == 50), 0);
    end
    send(0, 0, 0);
    check("single_err_cnt", s_cnt, 1);
    check("single_err_locked", s_lock, 1);
    check("single_err_pulses", pulse_cycles - pc, 1);

    send(0, 0, 1);
    send(0, 0, 0);
    check("clr_plain", s_cnt, 0);

    // 16 errors inside one window, aligned to a window start.
    guard = 0;
    while (m_win != 0 && guard < 2 * WINDOW) begin
      send(1, g_next(), 0);
      guard++;
    end
    check("window_align", m_win, 0);
    base = bits_sent;
    for (int i = 0; i < 300; i++) begin
      b = g_next();
      send(1, 1'(b) ^ ((i % 10 == 0) && (i < 160)), 0);
    end
    send(0, 0, 0);
    check("loss_point", loss_at - base, 151);
    check("relock_latency", lock_at - loss_at, 96);
    check("loss_errcnt", s_cnt, 16);
    check("relocked", s_lock, 1);

    // ClrCnt on the same cycle as an error leaves 1.
    b = g_next();
    send(1, ~1'(b), 1);
    send(0, 0, 0);
    check("clr_with_err", s_cnt, 1);

    // Stuck-at-zero input never locks.
    do_reset();
    r0 = lock_rises;
    repeat (2000) send(1, 0, 0);
    send(0, 0, 0);
    check("stuck_zero_rises", lock_rises - r0, 0);
    check("stuck_zero_locked", s_lock, 0);

    // Random BitEn gaps: still 96 valid bits to lock.
    do_reset();
    g_init(32'h0000_0001);
    while (bits_sent < 150) begin
      en = int'($urandom_range(1));
      send(1'(en), en ? g_next() : 1'b0, 0);
    end
    send(0, 0, 0);
    check("gap_lock_latency", lock_at, 96);
    check("gap_errcnt", s_cnt, 0);
    b = g_next();
    send(1, ~1'(b), 0);
    repeat (10) send(1, g_next(), 0);
    send(0, 0, 0);
    check("gap_err_cnt", s_cnt, 1);

    // Asynchronous reset mid-stream, then relock.
    do_reset();
    while (bits_sent < 150) begin
      en = int'($urandom_range(1));
      send(1'(en), en ? g_next() : 1'b0, 0);
    end
    send(0, 0, 0);
    check("post_rst_lock_latency", lock_at, 96);

    // Random soak: gaps, bursty errors, occasional clears.
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(99) < 70) ? 1 : 0;
      b  = en ? int'(g_next()) : 0;
      if (en && $urandom_range(49) == 0) b = 1 - b;
      send(1'(en), 1'(b), ($urandom_range(99) == 0));
    end
    send(0, 0, 0);
    send(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr32_chk.md
Name: lfsr32_chk

Overview:
- Serial PRBS checker at the receiving end of the lfsr32 loopback links.
- Takes the one-bit sequence produced by an lfsr32 generator (returned through an IO pad) and self-synchronises to it.
- Declares lock, then counts bit errors against a flywheel prediction.
- Drops lock on excessive errors and reacquires automatically.

Parameters:
- LOCK_GOOD, 64, consecutive correct predictions needed in VERIFY before lock (1..255).
- WINDOW, 1024, bit-window length for loss-of-lock evaluation (power of 2, 16..65536).
- LOSS_ERRS, 16, errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16, width of the error counter.

Ports:
- Clk  in  1  check clock; all state on rising edge.
- ARstb  in  1  asynchronous active-low reset; asserted asynchronously, released synchronously to Clk (synchronised by the instantiating level).
- BitEn  in  1  LFSRin is valid this cycle; when low, no state changes except ClrCnt.
- LFSRin  in  1  received serial bit.
- ClrCnt  in  1  synchronous clear of ErrCnt.
- Locked  out  1  checker is in LOCKED.
- ErrPulse  out  1  one-cycle pulse per detected bit error while LOCKED.
- ErrCnt  out  CNT_W  saturating count of errors seen while LOCKED.

Behaviour:
- Sequence definition (must match lfsr32): b[n] = b[n-32] ^ b[n-22] ^ b[n-2] ^ b[n-1].
- Shadow register R[31:0] holds history, with R[k] = b[n-1-k]. Prediction p = R[31]^R[21]^R[1]^R[0]. Shift: R <= {R[30:0], x}.
- Reset (ARstb low): state SEED, R=0, all counters 0, Locked=0, ErrPulse=0, ErrCnt=0. Reset mid-operation aborts immediately to this state.
- All outputs are registered. ErrPulse and Locked change in the cycle after the BitEn cycle that caused them.
- State SEED:
  - Each BitEn shifts in LFSRin and increments the seed count.
  - After the 32nd bit, go to VERIFY with good-count=0.
- State VERIFY:
  - Each BitEn compares LFSRin with p and shifts in LFSRin.
  - Match with R!=0 increments the good count; mismatch, or R==0 (all-zero/stuck input), clears it to 0.
  - When the good count reaches LOCK_GOOD, go to LOCKED with window count and window-error count at 0.
  - No ErrPulse or ErrCnt activity outside LOCKED.
- State LOCKED (flywheel):
  - Each BitEn shifts in p, not LFSRin, so a single corrupted bit produces exactly one error.
  - Mismatch: ErrPulse=1 next cycle, ErrCnt increments (saturating at 2^CNT_W-1), window-error count increments.
  - Window count increments per BitEn. On reaching WINDOW it wraps to 0, and the window-error count resets to 0 on the same cycle, after the loss evaluation for that bit.
  - When the window-error count reaches LOSS_ERRS: go to SEED, Locked=0, R keeps its value, seed count=0. The error that triggers loss is still counted.
- ClrCnt, in any state: ErrCnt <= 0. If it coincides with a counted error, ErrCnt <= 1. ErrPulse is unaffected.
- ErrCnt holds its value across loss of lock and relock; only reset or ClrCnt clears it.
- BitEn low: R, state and counters hold; ErrPulse=0.

Test Plan:
1. Reset, then stream a valid sequence from seed 0x00000001 with BitEn=1 every cycle → Locked rises after 32+64=96 bits (cycle 97). ErrCnt=0 for a further 5000 bits.
2. While locked, invert one bit → ErrPulse high for exactly 1 cycle, ErrCnt=1, Locked stays 1.
3. While locked, invert 16 bits inside one 1024-bit window → ErrCnt=16, and Locked falls the cycle after the 16th error. Relocks 96 bits later; ErrCnt stays 16.
4. Hold LFSRin=0 for 2000 bits after reset → Locked never asserts.
5. Assert ClrCnt on the same cycle as an error (ErrCnt=5) → ErrCnt=1. Plain ClrCnt → ErrCnt=0.
6. Toggle BitEn 50% randomly during a valid stream → lock after 96 valid bits with no errors. Pulse ARstb low mid-stream → Locked and ErrCnt go to 0 immediately, and relock takes 96 bits.
